// File: rtl/cnn_pkg.sv
// cnn_pkg: types, default resolutions and a reference transform shared by the
// activation/pooling stages.
//   state_e           : window FSM encoding (IDLE, COLLECT)
//   *_DEF             : default resolution constants
//   relu_requant_sat  : ReLU + arithmetic right shift + unsigned saturation at
//                       the default widths (ACC_RES_DEF in, OUT_RES_DEF out)
package cnn_pkg;

  localparam int unsigned ACC_RES_DEF   = 32;
  localparam int unsigned OUT_RES_DEF   = 8;
  localparam int unsigned POOL_SIZE_DEF = 4;
  localparam int unsigned SHIFT_DEF     = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Negative sums clamp to zero; positive sums are shifted down and clipped
  // to the largest unsigned output code.
  function automatic logic [OUT_RES_DEF-1:0] relu_requant_sat(
    input logic [ACC_RES_DEF-1:0] data,
    input logic [4:0]             shift
  );
    logic [ACC_RES_DEF-1:0] s;
    logic [OUT_RES_DEF-1:0] r;
    // Sign bit is known zero on the path that uses s, so a logical shift
    // is equivalent to the arithmetic one.
    s = data >> shift;
    if (data[ACC_RES_DEF-1]) begin
      r = {OUT_RES_DEF{1'b0}};
    end else if (|s[ACC_RES_DEF-1:OUT_RES_DEF]) begin
      r = {OUT_RES_DEF{1'b1}};
    end else begin
      r = s[OUT_RES_DEF-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/relu_requant.sv
// relu_requant: combinational per-sample transform.
//   data_i   [ACC_RESOLUTION]  signed accumulator sum
//   result_o [OUT_RESOLUTION]  0 if negative, else (data_i >>> SHIFT) clipped
//                              to 2^OUT_RESOLUTION-1
module relu_requant
  import cnn_pkg::*;
#(
  parameter int unsigned ACC_RESOLUTION = ACC_RES_DEF,
  parameter int unsigned OUT_RESOLUTION = OUT_RES_DEF,
  parameter int unsigned SHIFT          = SHIFT_DEF
) (
  input  logic [ACC_RESOLUTION-1:0] data_i,
  output logic [OUT_RESOLUTION-1:0] result_o
);

  logic [ACC_RESOLUTION-1:0] shifted_s;

  // Only used when the input is non-negative, so a logical shift suffices.
  assign shifted_s = data_i >> SHIFT;

  // ReLU then unsigned saturation on any bit above the output width.
  always_comb begin
    result_o = {OUT_RESOLUTION{1'b0}};
    if (data_i[ACC_RESOLUTION-1]) begin
      result_o = {OUT_RESOLUTION{1'b0}};
    end else if (|shifted_s[ACC_RESOLUTION-1:OUT_RESOLUTION]) begin
      result_o = {OUT_RESOLUTION{1'b1}};
    end else begin
      result_o = shifted_s[OUT_RESOLUTION-1:0];
    end
  end

endmodule

// File: rtl/relu_maxpool.sv
// relu_maxpool: ReLU/requantize each accumulator sum, max-pool over POOL_SIZE
// consecutive samples, emit one activation per window.
//   clk_i, rst_ni            clock, async active-low reset
//   clear_i                  synchronous discard of the partial window
//   acc_valid_i/acc_data_i   input sample (signed), acc_ready_o back-pressure
//   pool_valid_o/pool_data_o output holding register, pool_ready_i accept
module relu_maxpool
  import cnn_pkg::*;
#(
  parameter int unsigned ACC_RESOLUTION = ACC_RES_DEF,
  parameter int unsigned OUT_RESOLUTION = OUT_RES_DEF,
  parameter int unsigned POOL_SIZE      = POOL_SIZE_DEF,
  parameter int unsigned SHIFT          = SHIFT_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      acc_valid_i,
  input  logic [ACC_RESOLUTION-1:0] acc_data_i,
  output logic                      acc_ready_o,
  output logic                      pool_valid_o,
  output logic [OUT_RESOLUTION-1:0] pool_data_o,
  input  logic                      pool_ready_i
);

  localparam int unsigned CNT_W = $clog2(POOL_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_SIZE - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [OUT_RESOLUTION-1:0] max_q, max_d;
  logic                      pool_valid_q, pool_valid_d;
  logic [OUT_RESOLUTION-1:0] pool_data_q, pool_data_d;

  logic [OUT_RESOLUTION-1:0] t_s;
  logic [OUT_RESOLUTION-1:0] max_cand_s;
  logic                      last_sample_s;
  logic                      accept_s;
  logic                      pop_s;

  relu_requant #(
    .ACC_RESOLUTION(ACC_RESOLUTION),
    .OUT_RESOLUTION(OUT_RESOLUTION),
    .SHIFT         (SHIFT)
  ) u_relu_requant (
    .data_i  (acc_data_i),
    .result_o(t_s)
  );

  // Next accepted sample closes the window.
  assign last_sample_s = (state_q == COLLECT) && (cnt_q == CNT_LAST);
  // Only the final sample of a window can be stalled, and only when the
  // holding register is full and not being drained this cycle.
  assign acc_ready_o   = !clear_i && !(last_sample_s && pool_valid_q && !pool_ready_i);
  assign accept_s      = acc_valid_i && acc_ready_o;
  assign pop_s         = pool_valid_q && pool_ready_i;
  assign max_cand_s    = (t_s > max_q) ? t_s : max_q;

  assign pool_valid_o  = pool_valid_q;
  assign pool_data_o   = pool_data_q;

  // Next-state logic for window FSM, running max and output holding register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    max_d        = max_q;
    pool_data_d  = pool_data_q;
    // A pop empties the register unless a new result loads below.
    pool_valid_d = pool_valid_q && !pop_s;

    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
      max_d   = {OUT_RESOLUTION{1'b0}};
    end else if (accept_s) begin
      case (state_q)
        IDLE: begin
          max_d   = t_s;
          cnt_d   = CNT_W'(1);
          state_d = COLLECT;
        end
        COLLECT: begin
          if (cnt_q == CNT_LAST) begin
            pool_data_d  = max_cand_s;
            pool_valid_d = 1'b1;
            cnt_d        = {CNT_W{1'b0}};
            state_d      = IDLE;
          end else begin
            max_d = max_cand_s;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers; reset drops any partial window and pending output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      max_q        <= {OUT_RESOLUTION{1'b0}};
      pool_valid_q <= 1'b0;
      pool_data_q  <= {OUT_RESOLUTION{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      max_q        <= max_d;
      pool_valid_q <= pool_valid_d;
      pool_data_q  <= pool_data_d;
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Self-checking bench for relu_maxpool at default parameters (32/8/4/8).
module tb_relu_maxpool;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        acc_valid_i;
  logic [31:0] acc_data_i;
  logic        acc_ready_o;
  logic        pool_valid_o;
  logic [7:0]  pool_data_o;
  logic        pool_ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0][31:0] s;
    logic [7:0]       exp;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];
  logic [31:0] bp [8];

  always #5 clk_i = ~clk_i;

  relu_maxpool dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .acc_valid_i (acc_valid_i),
    .acc_data_i  (acc_data_i),
    .acc_ready_o (acc_ready_o),
    .pool_valid_o(pool_valid_o),
    .pool_data_o (pool_data_o),
    .pool_ready_i(pool_ready_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input logic [7:0] e);
    vec_t v;
    v.s[0] = a;
    v.s[1] = b;
    v.s[2] = c;
    v.s[3] = d;
    v.exp  = e;
    return v;
  endfunction

  initial begin
    rst_ni       = 1'b0;
    clear_i      = 1'b0;
    acc_valid_i  = 1'b0;
    acc_data_i   = 32'h0;
    pool_ready_i = 1'b1;

    vecs[0] = mk(32'h100, 32'h500, 32'h300, 32'h200, 8'h05);            // basic
    vecs[1] = mk(-1000, -5000, 32'h1000, -1, 8'h10);                    // relu
    vecs[2] = mk(32'h8000_0000, -1, -5000, -1000, 8'h00);               // all negative
    vecs[3] = mk(32'h7FFF_FFFF, 0, 0, 0, 8'hFF);                        // max positive
    vecs[4] = mk(32'h0000_FF00, 0, 0, 0, 8'hFF);                        // exact top code
    vecs[5] = mk(32'h0001_0000, 0, 0, 0, 8'hFF);                        // first saturating
    vecs[6] = mk(32'h0000_FEFF, 0, 0, 0, 8'hFE);                        // truncating shift
    vecs[7] = mk(32'h8000, 32'h7F00, 32'h0100, 32'h8100, 8'h81);        // unsigned compare, max last
    vecs[8] = mk(0, 0, 32'h0000_00FF, 0, 8'h00);                        // below one LSB

    bp[0] = 32'h100; bp[1] = 32'h300; bp[2] = 32'h200; bp[3] = 32'h000;
    bp[4] = 32'h700; bp[5] = 32'h100; bp[6] = 32'h200; bp[7] = 32'h300;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", {31'd0, pool_valid_o}, 32'd0);
    check("rst_data", {24'd0, pool_data_o}, 32'd0);
    rst_ni = 1'b1;
    #1;
    check("rst_ready", {31'd0, acc_ready_o}, 32'd1);
    tick();

    // Table: back-to-back windows, pool_ready held high
    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc_valid_i = 1'b1;
        acc_data_i  = vecs[i].s[j];
        #1;
        check($sformatf("tbl%0d_ready%0d", i, j), {31'd0, acc_ready_o}, 32'd1);
        tick();
        if (j < 3) begin
          check($sformatf("tbl%0d_valid%0d", i, j), {31'd0, pool_valid_o}, 32'd0);
        end else begin
          check($sformatf("tbl%0d_valid", i), {31'd0, pool_valid_o}, 32'd1);
          check($sformatf("tbl%0d_data", i), {24'd0, pool_data_o}, {24'd0, vecs[i].exp});
        end
      end
    end
    acc_valid_i = 1'b0;
    tick();
    check("tbl_tail_valid", {31'd0, pool_valid_o}, 32'd0);

    // Backpressure: maxima 3 then 7 with downstream stalled
    pool_ready_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      acc_valid_i = 1'b1;
      acc_data_i  = bp[k];
      #1;
      check($sformatf("bp_ready%0d", k), {31'd0, acc_ready_o}, 32'd1);
      tick();
      if (k >= 3) begin
        check($sformatf("bp_valid%0d", k), {31'd0, pool_valid_o}, 32'd1);
        check($sformatf("bp_data%0d", k), {24'd0, pool_data_o}, 32'h03);
      end
    end
    acc_data_i = bp[7];
    #1;
    check("bp_stall_ready", {31'd0, acc_ready_o}, 32'd0);
    tick();
    check("bp_hold_data1", {24'd0, pool_data_o}, 32'h03);
    check("bp_hold_ready", {31'd0, acc_ready_o}, 32'd0);
    tick();
    check("bp_hold_data2", {24'd0, pool_data_o}, 32'h03);
    check("bp_hold_valid", {31'd0, pool_valid_o}, 32'd1);
    pool_ready_i = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, acc_ready_o}, 32'd1);
    tick();
    check("bp_next_valid", {31'd0, pool_valid_o}, 32'd1);
    check("bp_next_data", {24'd0, pool_data_o}, 32'h07);
    acc_valid_i = 1'b0;
    tick();
    check("bp_drained", {31'd0, pool_valid_o}, 32'd0);

    // Clear discards a partial window and blocks the sample presented with it
    acc_valid_i = 1'b1;
    acc_data_i  = 32'h900;
    tick();
    tick();
    clear_i = 1'b1;
    #1;
    check("clr_ready", {31'd0, acc_ready_o}, 32'd0);
    tick();
    clear_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      acc_data_i = 32'(k + 1) << 8;
      tick();
      if (k < 3) begin
        check($sformatf("clr_valid%0d", k), {31'd0, pool_valid_o}, 32'd0);
      end else begin
        check("clr_valid", {31'd0, pool_valid_o}, 32'd1);
        check("clr_data", {24'd0, pool_data_o}, 32'h04);
      end
    end
    acc_valid_i = 1'b0;
    tick();
    check("clr_tail_valid", {31'd0, pool_valid_o}, 32'd0);

    // Reset with output pending and 3 samples of a partial window
    pool_ready_i = 1'b0;
    acc_valid_i  = 1'b1;
    acc_data_i   = 32'h500;
    repeat (4) tick();
    check("mr_pending_valid", {31'd0, pool_valid_o}, 32'd1);
    check("mr_pending_data", {24'd0, pool_data_o}, 32'h05);
    acc_data_i = 32'h100;
    repeat (3) tick();
    acc_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("mr_valid", {31'd0, pool_valid_o}, 32'd0);
    check("mr_data", {24'd0, pool_data_o}, 32'd0);
    tick();
    rst_ni       = 1'b1;
    pool_ready_i = 1'b1;
    acc_valid_i  = 1'b1;
    acc_data_i   = 32'h200;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) begin
        check($sformatf("mr_win_valid%0d", k), {31'd0, pool_valid_o}, 32'd0);
      end else begin
        check("mr_win_valid", {31'd0, pool_valid_o}, 32'd1);
        check("mr_win_data", {24'd0, pool_data_o}, 32'h02);
      end
    end
    acc_valid_i = 1'b0;
    tick();
    check("mr_tail_valid", {31'd0, pool_valid_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
